ripple_count_reader: RTL and testbench

//  Synchronous reader for the asynchronous JK ripple up/down counter output bus.
//  - Brings the glitchy, multi-bit ripple count into the clk domain.
//  - Accepts a value only after it has been stable for several samples.
//  - Reports the accepted value, the step size and any wrap-around.
//  - Accumulates counted events between host reads (req/ack handshake).

---
 rtl/ripple_count_reader.sv | 193 +++++++++++++++++++
 tb/tb_ripple_count_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_reader.sv
// ripple_count_reader
//   Purpose : brings the glitchy, asynchronous JK ripple up/down counter bus
//             into the clk domain. Accepts a count only after it has been
//             stable for STABLE_CNT synced samples. Reports the accepted
//             value, its modular step and any terminal-count crossing.
//             Accumulates counted events between host reads using a
//             req/ack handshake.
//   Latency : cnt_in settled before edge E0 gives valid after edge
//             E(STABLE_CNT+1), which is 4 edges at the default.
//   Ports   : clk, rst (sync, active-high)
//             cnt_in[SIZE], mode       raw async counter bus and direction
//             rd_req                   host read request (level)
//             value[SIZE], valid       last accepted count, 1-cycle change pulse
//             delta[SIZE], wrap        step of the last acceptance, crossing pulse
//             rd_ack                   1-cycle pulse completing a read
//             rd_total[ACC_W], acc_sat events and saturation since the previous read
module ripple_count_reader #(
   parameter int SIZE       = 4,
   parameter int STABLE_CNT = 2,
   parameter int ACC_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SIZE-1:0]  cnt_in,
   input  logic             mode,
   input  logic             rd_req,
   output logic [SIZE-1:0]  value,
   output logic             valid,
   output logic [SIZE-1:0]  delta,
   output logic             wrap,
   output logic             rd_ack,
   output logic [ACC_W-1:0] rd_total,
   output logic             acc_sat
);

   // The run counter must hold values 0..STABLE_CNT.
   localparam int RUN_W = $clog2(STABLE_CNT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
   localparam logic [RUN_W-1:0] RUN_ARM = RUN_W'(STABLE_CNT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } rd_state_t;

   // Two-flop synchronisers. The s1 stage feeds only s2.
   logic [SIZE-1:0]  cnt_s1, cnt_s2;
   logic             mode_s1, mode_s2;

   // Stability filter state.
   logic [SIZE-1:0]  cand;
   logic [RUN_W-1:0] run;

   // Event accumulator.
   logic [ACC_W-1:0] acc;
   logic             sat_flag;

   rd_state_t        state, state_nxt;
   logic             capture;

   // Combinational helpers.
   logic             same;
   logic [RUN_W-1:0] run_nxt;
   logic             stable;
   logic             accept;
   logic [SIZE-1:0]  step;
   logic             crossed;
   logic [ACC_W:0]   acc_sum;
   logic             ovf;
   logic [ACC_W-1:0] acc_clamped;

   // ---------------------------------------------------------------
   // Filter: cand always follows s2. run counts how many consecutive
   // synced samples have matched it, saturating at STABLE_CNT.
   // ---------------------------------------------------------------
   assign same    = (cnt_s2 == cand);
   assign run_nxt = !same            ? RUN_W'(1) :
                    (run == RUN_MAX) ? RUN_MAX   :
                                       run + RUN_W'(1);

   // Accept only on the sample that completes a run of exactly
   // STABLE_CNT equal samples. A run that has already been accepted
   // (or equals value) saturates and cannot fire twice.
   generate
      if (STABLE_CNT == 1) begin : g_single
         assign stable = 1'b1;
      end else begin : g_multi
         assign stable = same && (run == RUN_ARM);
      end
   endgenerate

   assign accept  = stable && (cnt_s2 != value);

   // The direction is taken from the synced mode at the accept edge.
   // Subtraction wraps modulo 2^SIZE.
   assign step    = mode_s2 ? (cnt_s2 - value) : (value - cnt_s2);
   assign crossed = mode_s2 ? (cnt_s2 < value) : (cnt_s2 > value);

   // The step is zero-extended into the accumulator. One spare bit
   // catches overflow, which is then clamped to all-ones.
   assign acc_sum     = {1'b0, acc} + (accept ? (ACC_W+1)'(step) : '0);
   assign ovf         = acc_sum[ACC_W];
   assign acc_clamped = ovf ? '1 : acc_sum[ACC_W-1:0];

   // ---------------------------------------------------------------
   // Read handshake: one capture per rd_req assertion.
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) begin
               capture   = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (!rd_req) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign rd_ack = (state == ACK);

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_s1   <= '0;
         cnt_s2   <= '0;
         mode_s1  <= 1'b0;
         mode_s2  <= 1'b0;
         cand     <= '0;
         run      <= '0;
         value    <= '0;
         valid    <= 1'b0;
         delta    <= '0;
         wrap     <= 1'b0;
         acc      <= '0;
         sat_flag <= 1'b0;
         rd_total <= '0;
         acc_sat  <= 1'b0;
      end else begin
         cnt_s1  <= cnt_in;
         cnt_s2  <= cnt_s1;
         mode_s1 <= mode;
         mode_s2 <= mode_s1;

         cand    <= cnt_s2;
         run     <= run_nxt;

         valid   <= accept;
         wrap    <= accept && crossed;
         if (accept) begin
            value <= cnt_s2;
            delta <= step;
         end

         // A step accepted on the capture edge goes into the reported
         // total. The fresh accumulator starts from zero, so no event is
         // lost or double counted.
         if (capture) begin
            rd_total <= acc_clamped;
            acc_sat  <= sat_flag || ovf;
            acc      <= '0;
            sat_flag <= 1'b0;
         end else begin
            acc      <= acc_clamped;
            sat_flag <= sat_flag || ovf;
         end
      end
   end

endmodule

// File: tb/tb_ripple_count_reader.sv
module tb_ripple_count_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cnt_in;
   logic       mode;
   logic       rd_req;
   logic [3:0] value;
   logic       valid;
   logic [3:0] delta;
   logic       wrap;
   logic       rd_ack;
   logic [7:0] rd_total;
   logic       acc_sat;

   ripple_count_reader #(.SIZE(4), .STABLE_CNT(2), .ACC_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .cnt_in   (cnt_in),
      .mode     (mode),
      .rd_req   (rd_req),
      .value    (value),
      .valid    (valid),
      .delta    (delta),
      .wrap     (wrap),
      .rd_ack   (rd_ack),
      .rd_total (rd_total),
      .acc_sat  (acc_sat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pulse counters over a stimulus window.
   int n_valid, n_wrap, n_ack;

   // ---------------- reference model ----------------
   // Synced samples are the raw inputs delayed by two edges. A count
   // is accepted when the synced stream has shown it for exactly
   // STABLE_CNT consecutive samples and it differs from the current value.
   localparam int SC  = 2;
   localparam int MAXACC = 255;
   int q_cnt[$];
   int q_mode[$];
   int last_s2, runlen;
   bit have_last;
   int m_value, m_delta, m_total, m_acc;
   bit m_valid, m_wrap, m_ack, m_sat, m_flag;
   int edge_n, last_cap;
   bit ever_cap, low_seen;

   function automatic void model_reset();
      q_cnt     = '{0, 0};
      q_mode    = '{0, 0};
      have_last = 1'b0;
      runlen    = 0;
      last_s2   = 0;
      m_value   = 0;
      m_delta   = 0;
      m_total   = 0;
      m_acc     = 0;
      m_valid   = 1'b0;
      m_wrap    = 1'b0;
      m_ack     = 1'b0;
      m_sat     = 1'b0;
      m_flag    = 1'b0;
      ever_cap  = 1'b0;
      low_seen  = 1'b0;
      last_cap  = 0;
   endfunction

   function automatic void model_edge(bit r, int c, bit md, bit rq);
      int s2, dir, dn, sum;
      bit ok, cap, crossed;
      edge_n++;
      if (r) begin
         model_reset();
         return;
      end
      s2  = q_cnt.pop_front();
      q_cnt.push_back(c);
      dir = q_mode.pop_front();
      q_mode.push_back(int'(md));

      runlen    = (have_last && s2 == last_s2) ? runlen + 1 : 1;
      have_last = 1'b1;
      last_s2   = s2;

      ok      = (runlen == SC) && (s2 != m_value);
      dn      = (dir != 0) ? (s2 - m_value + 16) % 16 : (m_value - s2 + 16) % 16;
      crossed = (dir != 0) ? (s2 < m_value) : (s2 > m_value);

      m_valid = ok;
      m_wrap  = ok && crossed;
      if (ok) begin
         m_value = s2;
         m_delta = dn;
      end

      sum = m_acc + (ok ? dn : 0);
      cap = rq && (!ever_cap || low_seen);
      if (cap) begin
         m_total  = (sum > MAXACC) ? MAXACC : sum;
         m_sat    = m_flag || (sum > MAXACC);
         m_acc    = 0;
         m_flag   = 1'b0;
         ever_cap = 1'b1;
         low_seen = 1'b0;
         last_cap = edge_n;
      end else begin
         m_acc  = (sum > MAXACC) ? MAXACC : sum;
         m_flag = m_flag || (sum > MAXACC);
         if (ever_cap && !rq && edge_n >= last_cap + 2) low_seen = 1'b1;
      end
      m_ack = cap;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge,
   // then compare every output 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_edge(rst, int'(cnt_in), mode, rd_req);
      #1;
      n_valid += int'(valid);
      n_wrap  += int'(wrap);
      n_ack   += int'(rd_ack);
      chk("model value",    int'(value),    m_value);
      chk("model valid",    int'(valid),    int'(m_valid));
      chk("model delta",    int'(delta),    m_delta);
      chk("model wrap",     int'(wrap),     int'(m_wrap));
      chk("model rd_ack",   int'(rd_ack),   int'(m_ack));
      chk("model rd_total", int'(rd_total), m_total);
      chk("model acc_sat",  int'(acc_sat),  int'(m_sat));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_counts();
      n_valid = 0;
      n_wrap  = 0;
      n_ack   = 0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      cycles(n);
      rst = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0] cnt;
      logic       md;
      int         hold;
      logic [3:0] exp_value;
      logic [3:0] exp_delta;
      int         exp_valids;
      int         exp_wraps;
   } vec_t;

   vec_t tbl[9];

   initial begin
      rst    = 1'b1;
      cnt_in = 4'd0;
      mode   = 1'b1;
      rd_req = 1'b0;
      edge_n = 0;
      model_reset();
      clear_counts();

      tbl[0] = '{4'd1,  1'b1, 6, 4'd1,  4'd1,  1, 0};
      tbl[1] = '{4'd15, 1'b1, 6, 4'd15, 4'd14, 1, 0};
      tbl[2] = '{4'd0,  1'b1, 6, 4'd0,  4'd1,  1, 1};
      tbl[3] = '{4'd15, 1'b0, 6, 4'd15, 4'd1,  1, 1};
      tbl[4] = '{4'd15, 1'b1, 6, 4'd15, 4'd1,  0, 0};
      tbl[5] = '{4'd3,  1'b0, 6, 4'd3,  4'd12, 1, 0};
      tbl[6] = '{4'd8,  1'b0, 1, 4'd3,  4'd12, 0, 0};
      tbl[7] = '{4'd3,  1'b0, 6, 4'd3,  4'd12, 0, 0};
      tbl[8] = '{4'd4,  1'b0, 6, 4'd4,  4'd15, 1, 1};

      // Reset state
      do_reset(3);
      chk("reset value",    int'(value),    0);
      chk("reset valid",    int'(valid),    0);
      chk("reset rd_total", int'(rd_total), 0);
      chk("reset rd_ack",   int'(rd_ack),   0);

      // Latency: valid appears on the fourth edge after the change.
      cnt_in = 4'd1;
      clear_counts();
      cycles(3);
      chk("latency early valid", n_valid, 0);
      cycle();
      chk("latency valid", int'(valid), 1);
      chk("latency value", int'(value), 1);
      chk("latency delta", int'(delta), 1);
      cycles(2);

      // Table: up/down steps, wraps, mode-only change, 1-cycle glitch.
      do_reset(3);
      for (int i = 0; i < 9; i++) begin
         cnt_in = tbl[i].cnt;
         mode   = tbl[i].md;
         clear_counts();
         cycles(tbl[i].hold);
         chk($sformatf("tbl%0d value", i),  int'(value), int'(tbl[i].exp_value));
         chk($sformatf("tbl%0d delta", i),  int'(delta), int'(tbl[i].exp_delta));
         chk($sformatf("tbl%0d valids", i), n_valid,     tbl[i].exp_valids);
         chk($sformatf("tbl%0d wraps", i),  n_wrap,      tbl[i].exp_wraps);
      end

      // Reads: 0->1->2->3 then two reads.
      mode = 1'b1;
      cnt_in = 4'd0;
      do_reset(3);
      for (int v = 1; v <= 3; v++) begin
         cnt_in = 4'(v);
         cycles(6);
      end
      clear_counts();
      rd_req = 1'b1;
      cycles(4);
      chk("read1 acks",  n_ack, 1);
      chk("read1 total", int'(rd_total), 3);
      rd_req = 1'b0;
      cycles(2);
      clear_counts();
      rd_req = 1'b1;
      cycles(4);
      chk("read2 acks",  n_ack, 1);
      chk("read2 total", int'(rd_total), 0);
      rd_req = 1'b0;
      cycles(2);

      // Saturation: 3->8 then 39 steps of 8 gives 317 events.
      for (int i = 0; i < 40; i++) begin
         cnt_in = (i % 2 == 0) ? 4'd8 : 4'd0;
         cycles(6);
      end
      rd_req = 1'b1;
      cycles(3);
      chk("sat total", int'(rd_total), 255);
      chk("sat flag",  int'(acc_sat),  1);
      rd_req = 1'b0;
      cycles(2);
      rd_req = 1'b1;
      cycles(3);
      chk("post-sat total", int'(rd_total), 0);
      chk("post-sat flag",  int'(acc_sat),  0);
      rd_req = 1'b0;
      cycles(2);

      // Accept on the capture edge is counted in that read.
      cnt_in = 4'd5;
      cycles(3);
      rd_req = 1'b1;
      cycle();
      chk("edge accept valid",  int'(valid),    1);
      chk("edge accept ack",    int'(rd_ack),   1);
      chk("edge accept total",  int'(rd_total), 5);
      rd_req = 1'b0;
      cycles(2);

      // Reset while in ACK drops the handshake; a held request acks once.
      rd_req = 1'b1;
      cycle();
      chk("pre-reset ack", int'(rd_ack), 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("reset-in-ack rd_ack", int'(rd_ack), 0);
      chk("reset-in-ack value",  int'(value),  0);
      clear_counts();
      cycles(10);
      chk("held req acks", n_ack, 1);
      rd_req = 1'b0;
      cycles(2);

      // Randomised traffic against the model.
      for (int seg = 0; seg < 600; seg++) begin
         int hold;
         cnt_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) mode = ~mode;
         hold = $urandom_range(1, 7);
         for (int h = 0; h < hold; h++) begin
            if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
            rst = ($urandom_range(0, 399) == 0);
            cycle();
         end
         rst = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
